// File: rtl/video_timing_if.sv
// Bundle of the raster generator's enable, scroll and CPU handshake inputs
// together with every timing output it produces.
// master: the timing generator itself; slave: whatever drives/consumes it.
interface video_timing_if;
  logic       ce12;
  logic [7:0] roll;
  logic       int_ack;
  logic [9:0] hctr;
  logic [8:0] vctr;
  logic       hsync_n;
  logic       vsync_n;
  logic       blank;
  logic       active;
  logic       border;
  logic       fetch;
  logic [7:0] row_addr;
  logic [4:0] col_addr;
  logic       line_start;
  logic       frame_start;
  logic       int_rq;

  modport master (
    input  ce12, roll, int_ack,
    output hctr, vctr, hsync_n, vsync_n, blank, active, border, fetch,
           row_addr, col_addr, line_start, frame_start, int_rq
  );

  modport slave (
    output ce12, roll, int_ack,
    input  hctr, vctr, hsync_n, vsync_n, blank, active, border, fetch,
           row_addr, col_addr, line_start, frame_start, int_rq
  );
endinterface

// File: rtl/video_timing.sv
// Vector-06C raster timing generator. Advances on the 12 MHz enable inside
// the 24 MHz domain and produces counters, syncs, blanking, border/active
// flags, video fetch strobes with addresses, and the 50 Hz frame interrupt.
// Every output is registered from the next-state counts, so flags always
// agree with the hctr/vctr visible in the same cycle.
module video_timing #(
  parameter logic [9:0] H_TOTAL     = 10'd768,
  parameter logic [9:0] H_ACT_START = 10'd128,
  parameter logic [9:0] H_ACT_END   = 10'd640,
  parameter logic [9:0] HSYNC_START = 10'd680,
  parameter logic [9:0] HSYNC_END   = 10'd736,
  parameter logic [8:0] V_TOTAL     = 9'd312,
  parameter logic [8:0] V_ACT_START = 9'd40,
  parameter logic [8:0] V_ACT_END   = 9'd296,
  parameter logic [8:0] VSYNC_START = 9'd300,
  parameter logic [8:0] VSYNC_END   = 9'd304,
  parameter logic [6:0] INT_HOLD    = 7'd96
) (
  input  logic           clk24,
  input  logic           reset,
  video_timing_if.master vt
);

  // Fetches run one byte (16 ticks) ahead of the 512-tick active window.
  localparam logic [9:0] FETCH_START = H_ACT_START - 10'd16;
  localparam logic [9:0] BLANK_H     = HSYNC_START - 10'd8;
  localparam logic [8:0] BLANK_V     = VSYNC_START - 9'd2;

  logic [9:0] hctr_q, hctr_d;
  logic [8:0] vctr_q, vctr_d;
  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;
  logic       blank_q, blank_d;
  logic       active_q, active_d;
  logic       border_q, border_d;
  logic       fetch_q, fetch_d;
  logic [7:0] row_addr_q, row_addr_d;
  logic [4:0] col_addr_q, col_addr_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       int_rq_q, int_rq_d;
  logic [6:0] int_cnt_q, int_cnt_d;
  logic [7:0] roll_q, roll_d;

  logic       h_act;
  logic       v_act;
  logic [9:0] fetch_off;
  logic [7:0] line_off;

  // Next counts and every raster decode, evaluated only on a ce12 cycle.
  always_comb begin
    hctr_d        = hctr_q;
    vctr_d        = vctr_q;
    hsync_n_d     = hsync_n_q;
    vsync_n_d     = vsync_n_q;
    blank_d       = blank_q;
    active_d      = active_q;
    border_d      = border_q;
    row_addr_d    = row_addr_q;
    col_addr_d    = col_addr_q;
    roll_d        = roll_q;
    fetch_d       = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    h_act         = 1'b0;
    v_act         = 1'b0;
    fetch_off     = '0;
    line_off      = '0;
    if (vt.ce12) begin
      if (hctr_q == H_TOTAL - 10'd1) begin
        hctr_d = '0;
        vctr_d = (vctr_q == V_TOTAL - 9'd1) ? '0 : vctr_q + 9'd1;
      end else begin
        hctr_d = hctr_q + 10'd1;
      end
      h_act         = (hctr_d >= H_ACT_START) && (hctr_d < H_ACT_END);
      v_act         = (vctr_d >= V_ACT_START) && (vctr_d < V_ACT_END);
      hsync_n_d     = !((hctr_d >= HSYNC_START) && (hctr_d < HSYNC_END));
      vsync_n_d     = !((vctr_d >= VSYNC_START) && (vctr_d < VSYNC_END));
      blank_d       = (hctr_d >= BLANK_H) || (vctr_d >= BLANK_V);
      active_d      = h_act && v_act;
      border_d      = !blank_d && !active_d;
      line_start_d  = (hctr_d == '0);
      frame_start_d = line_start_d && (vctr_d == '0);
      if (frame_start_d) begin
        roll_d = vt.roll;
      end
      // Offset below 512 with zero low nibble marks the 32 byte slots;
      // bitmap rows count downwards from the scroll value.
      fetch_off = hctr_d - FETCH_START;
      line_off  = 8'(vctr_d - V_ACT_START);
      if (v_act && (hctr_d >= FETCH_START) && !fetch_off[9] &&
          (fetch_off[3:0] == 4'd0)) begin
        fetch_d    = 1'b1;
        col_addr_d = fetch_off[8:4];
        row_addr_d = roll_q - line_off;
      end
    end
  end

  // Frame interrupt: set wins over ack, ack clears at once, else time out.
  always_comb begin
    int_rq_d  = int_rq_q;
    int_cnt_d = int_cnt_q;
    if (frame_start_d) begin
      int_rq_d  = 1'b1;
      int_cnt_d = '0;
    end else if (int_rq_q && vt.int_ack) begin
      int_rq_d = 1'b0;
    end else if (int_rq_q && vt.ce12) begin
      if (int_cnt_q == INT_HOLD - 7'd1) begin
        int_rq_d = 1'b0;
      end else begin
        int_cnt_d = int_cnt_q + 7'd1;
      end
    end
  end

  // State registers, all forced to idle values by the asynchronous reset.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      hctr_q        <= '0;
      vctr_q        <= '0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      blank_q       <= 1'b1;
      active_q      <= 1'b0;
      border_q      <= 1'b0;
      fetch_q       <= 1'b0;
      row_addr_q    <= '0;
      col_addr_q    <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      int_rq_q      <= 1'b0;
      int_cnt_q     <= '0;
      roll_q        <= '0;
    end else begin
      hctr_q        <= hctr_d;
      vctr_q        <= vctr_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      blank_q       <= blank_d;
      active_q      <= active_d;
      border_q      <= border_d;
      fetch_q       <= fetch_d;
      row_addr_q    <= row_addr_d;
      col_addr_q    <= col_addr_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      int_rq_q      <= int_rq_d;
      int_cnt_q     <= int_cnt_d;
      roll_q        <= roll_d;
    end
  end

  assign vt.hctr        = hctr_q;
  assign vt.vctr        = vctr_q;
  assign vt.hsync_n     = hsync_n_q;
  assign vt.vsync_n     = vsync_n_q;
  assign vt.blank       = blank_q;
  assign vt.active      = active_q;
  assign vt.border      = border_q;
  assign vt.fetch       = fetch_q;
  assign vt.row_addr    = row_addr_q;
  assign vt.col_addr    = col_addr_q;
  assign vt.line_start  = line_start_q;
  assign vt.frame_start = frame_start_q;
  assign vt.int_rq      = int_rq_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing. Horizontal geometry is the real one; the vertical
// geometry is compacted to a 10-line frame so several whole frames fit in a
// short run. The reference is a global ce12 tick count n since reset release:
// position, flags, fetches and interrupt all follow from n arithmetically.
module tb_video_timing;

  localparam int H_TOTAL     = 768;
  localparam int H_ACT_START = 128;
  localparam int H_ACT_END   = 640;
  localparam int HSYNC_START = 680;
  localparam int HSYNC_END   = 736;
  localparam int V_TOTAL     = 10;
  localparam int V_ACT_START = 2;
  localparam int V_ACT_END   = 6;
  localparam int VSYNC_START = 8;
  localparam int VSYNC_END   = 9;
  localparam int INT_HOLD    = 96;
  localparam int FRAME       = H_TOTAL * V_TOTAL;

  logic clk24 = 1'b0;
  logic reset = 1'b1;

  video_timing_if vif ();

  video_timing #(
    .H_TOTAL    (10'(H_TOTAL)),
    .H_ACT_START(10'(H_ACT_START)),
    .H_ACT_END  (10'(H_ACT_END)),
    .HSYNC_START(10'(HSYNC_START)),
    .HSYNC_END  (10'(HSYNC_END)),
    .V_TOTAL    (9'(V_TOTAL)),
    .V_ACT_START(9'(V_ACT_START)),
    .V_ACT_END  (9'(V_ACT_END)),
    .VSYNC_START(9'(VSYNC_START)),
    .VSYNC_END  (9'(VSYNC_END)),
    .INT_HOLD   (7'(INT_HOLD))
  ) dut (
    .clk24(clk24),
    .reset(reset),
    .vt   (vif)
  );

  always #5 clk24 = ~clk24;

  // Reference state
  longint     n = 0;
  bit         ce_now = 1'b0;
  bit         int_live = 1'b0;
  longint     set_tick = 0;
  logic [7:0] m_roll = 8'h00;
  logic [7:0] m_row = 8'h00;
  logic [4:0] m_col = 5'd0;
  longint     mh, mv, mf, ml;
  bit         prev_int, mfs;

  int checks = 0;
  int errors = 0;

  // Event counters observed on the DUT
  int ls_cnt = 0, hs_low = 0, fs_total = 0;
  int win_fs = 0, win_act = 0, win_vs = 0, int_hi = 0;
  int l2_cnt = 0;
  bit rec_en = 1'b1;
  logic [9:0] l2_first_h = '0;
  logic [4:0] l2_last_col = '0;
  logic [7:0] l2_row = 8'h55, l3_row = 8'h55, l4_row = 8'h55, f1_l2_row = 8'h55;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic bit is_fetch(input longint h, input longint v);
    return (v >= V_ACT_START) && (v < V_ACT_END) &&
           (h >= H_ACT_START - 16) && (h < H_ACT_END - 16) &&
           ((h - (H_ACT_START - 16)) % 16 == 0);
  endfunction

  // Full output comparison against the tick-count reference
  task automatic check_output();
    longint h, v;
    bit e_hs, e_vs, e_blank, e_act, e_border;
    h = n % H_TOTAL;
    v = (n / H_TOTAL) % V_TOTAL;
    if (n == 0) begin
      e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b1; e_act = 1'b0; e_border = 1'b0;
    end else begin
      e_hs     = !((h >= HSYNC_START) && (h < HSYNC_END));
      e_vs     = !((v >= VSYNC_START) && (v < VSYNC_END));
      e_blank  = (h >= HSYNC_START - 8) || (v >= VSYNC_START - 2);
      e_act    = (h >= H_ACT_START) && (h < H_ACT_END) && (v >= V_ACT_START) && (v < V_ACT_END);
      e_border = !e_blank && !e_act;
    end
    check("hctr", 32'(vif.hctr), 32'(h));
    check("vctr", 32'(vif.vctr), 32'(v));
    check("hsync_n", 32'(vif.hsync_n), 32'(e_hs));
    check("vsync_n", 32'(vif.vsync_n), 32'(e_vs));
    check("blank", 32'(vif.blank), 32'(e_blank));
    check("active", 32'(vif.active), 32'(e_act));
    check("border", 32'(vif.border), 32'(e_border));
    check("line_start", 32'(vif.line_start), 32'(ce_now && h == 0));
    check("frame_start", 32'(vif.frame_start), 32'(ce_now && h == 0 && v == 0));
    check("fetch", 32'(vif.fetch), 32'(ce_now && is_fetch(h, v)));
    check("row_addr", 32'(vif.row_addr), 32'(m_row));
    check("col_addr", 32'(vif.col_addr), 32'(m_col));
    check("int_rq", 32'(vif.int_rq), 32'(int_live && (n - set_tick) < INT_HOLD));
  endtask

  // Reference update at each edge, then compare and tally 1 ns later
  always @(posedge clk24) begin
    if (reset) begin
      n = 0; ce_now = 1'b0; int_live = 1'b0;
      m_roll = 8'h00; m_row = 8'h00; m_col = 5'd0;
    end else begin
      ce_now   = vif.ce12;
      prev_int = int_live && (n - set_tick) < INT_HOLD;
      if (ce_now) n++;
      mh  = n % H_TOTAL;
      mv  = (n / H_TOTAL) % V_TOTAL;
      mfs = ce_now && (n % FRAME == 0);
      if (mfs) begin
        m_roll = vif.roll; int_live = 1'b1; set_tick = n;
      end else if (vif.int_ack && prev_int) begin
        int_live = 1'b0;
      end
      if (ce_now && is_fetch(mh, mv)) begin
        m_col = 5'((mh - (H_ACT_START - 16)) / 16);
        m_row = 8'(m_roll - (mv - V_ACT_START));
      end
    end
    #1;
    check_output();
    if (vif.line_start) ls_cnt++;
    if (ce_now && !vif.hsync_n) hs_low++;
    if (vif.frame_start) begin fs_total++; win_fs++; end
    if (ce_now && vif.active) win_act++;
    if (ce_now && !vif.vsync_n) win_vs++;
    if (ce_now && vif.int_rq && fs_total == 1) int_hi++;
    if (rec_en && vif.fetch) begin
      mf = n / FRAME;
      ml = (n / H_TOTAL) % V_TOTAL;
      if (mf == 0 && ml == V_ACT_START) begin
        l2_cnt++;
        if (l2_cnt == 1) begin l2_first_h = vif.hctr; l2_row = vif.row_addr; end
        l2_last_col = vif.col_addr;
      end
      if (mf == 0 && ml == V_ACT_START + 1) l3_row = vif.row_addr;
      if (mf == 0 && ml == V_ACT_START + 2) l4_row = vif.row_addr;
      if (mf == 1 && ml == V_ACT_START) f1_l2_row = vif.row_addr;
    end
  end

  // Random ce12 cadence until the tick count reaches target (bounded)
  task automatic drive_until(input longint target);
    longint budget;
    budget = 1000 + 16 * (target - n);
    @(negedge clk24);
    vif.int_ack = 1'b0;
    while (n < target) begin
      if (budget <= 0) begin
        checks++; errors++;
        $display("[TB] FAIL timeout: tick %0d, required %0d", n, target);
        finish_sim();
      end
      budget--;
      vif.ce12 = ($urandom_range(0, 7) != 0);
      if (n < 7000 && $urandom_range(0, 299) == 0) vif.int_ack = 1'b1;
      if (n > 12288 && $urandom_range(0, 499) == 0) vif.roll = 8'($urandom);
      @(negedge clk24);
      vif.int_ack = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hctr"}, 32'(vif.hctr), 0);
    check({tag, "_vctr"}, 32'(vif.vctr), 0);
    check({tag, "_hsync_n"}, 32'(vif.hsync_n), 1);
    check({tag, "_vsync_n"}, 32'(vif.vsync_n), 1);
    check({tag, "_blank"}, 32'(vif.blank), 1);
    check({tag, "_active"}, 32'(vif.active), 0);
    check({tag, "_border"}, 32'(vif.border), 0);
    check({tag, "_int_rq"}, 32'(vif.int_rq), 0);
    check({tag, "_row_addr"}, 32'(vif.row_addr), 0);
    check({tag, "_col_addr"}, 32'(vif.col_addr), 0);
  endtask

  initial begin
    vif.ce12 = 1'b0; vif.roll = 8'h00; vif.int_ack = 1'b0;
    repeat (3) @(negedge clk24);
    check_reset_values("rst");
    reset = 1'b0;
    ls_cnt = 0; hs_low = 0; fs_total = 0;

    // First line: one wrap, 56 hsync ticks
    drive_until(H_TOTAL);
    check("line1_hctr", 32'(vif.hctr), 0);
    check("line1_vctr", 32'(vif.vctr), 1);
    check("line1_line_starts", 32'(ls_cnt), 1);
    check("line1_hsync_ticks", 32'(hs_low), 56);
    vif.ce12 = 1'b1;

    // Scroll written mid-frame after line 3 fetched
    drive_until(3 * H_TOTAL + 700);
    vif.roll = 8'h10;
    vif.ce12 = 1'b1;

    drive_until(FRAME);
    win_fs = 0; win_act = 0; win_vs = 0;
    vif.ce12 = 1'b1;
    drive_until(2 * FRAME);
    check("frame_starts_per_frame", 32'(win_fs), 1);
    check("active_ticks_per_frame", 32'(win_act), 512 * 4);
    check("vsync_ticks_per_frame", 32'(win_vs), 768);
    check("int_rq_hold_ticks", 32'(int_hi), 96);
    check("fetches_first_line", 32'(l2_cnt), 32);
    check("first_fetch_hctr", 32'(l2_first_h), 112);
    check("first_fetch_row", 32'(l2_row), 32'h00);
    check("last_fetch_col", 32'(l2_last_col), 31);
    check("second_line_row", 32'(l3_row), 32'hFF);
    check("row_after_roll_write", 32'(l4_row), 32'hFE);
    check("row_next_frame", 32'(f1_l2_row), 32'h10);
    vif.ce12 = 1'b1;

    // Acknowledge five ticks after set
    drive_until(2 * FRAME + 5);
    vif.int_ack = 1'b1;
    vif.ce12 = ($urandom_range(0, 1) != 0);
    @(negedge clk24);
    vif.int_ack = 1'b0;
    check("ack_clears_int_rq", 32'(vif.int_rq), 0);

    // Acknowledge coincident with the setting frame_start
    drive_until(3 * FRAME - 1);
    vif.ce12 = 1'b1;
    vif.int_ack = 1'b1;
    @(negedge clk24);
    vif.int_ack = 1'b0;
    vif.ce12 = 1'b0;
    check("coincident_frame_start", 32'(vif.frame_start), 1);
    check("coincident_int_rq", 32'(vif.int_rq), 1);
    @(negedge clk24);
    check("coincident_int_rq_held", 32'(vif.int_rq), 1);

    // Freeze with ce12 low
    drive_until(3 * FRAME + 60);
    vif.ce12 = 1'b0;
    repeat (100) @(negedge clk24);
    check("freeze_hctr", 32'(vif.hctr), 60);
    check("freeze_vctr", 32'(vif.vctr), 0);
    check("freeze_border", 32'(vif.border), 1);
    check("freeze_blank", 32'(vif.blank), 0);
    check("freeze_int_rq", 32'(vif.int_rq), 1);

    // Asynchronous reset at hctr=300 on an active line
    drive_until(3 * FRAME + 5 * H_TOTAL + 300);
    vif.ce12 = 1'b0;
    rec_en = 1'b0;
    check("pre_reset_hctr", 32'(vif.hctr), 300);
    check("pre_reset_vctr", 32'(vif.vctr), 5);
    check("pre_reset_active", 32'(vif.active), 1);
    #2 reset = 1'b1;
    #1 check_reset_values("async");
    repeat (2) @(negedge clk24);
    reset = 1'b0;
    fs_total = 0;
    vif.ce12 = 1'b1;
    drive_until(FRAME - 1);
    check("no_early_frame_start", 32'(fs_total), 0);
    vif.ce12 = 1'b1;
    @(negedge clk24);
    check("frame_start_after_reset", 32'(vif.frame_start), 1);
    check("frame_start_count_after_reset", 32'(fs_total), 1);
    finish_sim();
  end

endmodule
